// File: rtl/fpu_pkg.sv
// Shared encodings for the FPU issue stage: RISC-V funct7 opcodes and the sequencer state.
package fpu_pkg;

    localparam logic [6:0] F7_FADD     = 7'h00;
    localparam logic [6:0] F7_FSUB     = 7'h04;
    localparam logic [6:0] F7_FMUL     = 7'h08;
    localparam logic [6:0] F7_FDIV     = 7'h0C;
    localparam logic [6:0] F7_FSGNJ    = 7'h10;
    localparam logic [6:0] F7_FCMP     = 7'h50;
    localparam logic [6:0] F7_FCVT_S_W = 7'h68;
    localparam logic [6:0] F7_FMV_W_S  = 7'h70;
    localparam logic [6:0] F7_FMV_S_W  = 7'h78;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_lat_lut.sv
// Maps an op's funct7 to the number of extra cycles the FPU needs before its result is valid.
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int FADD_LAT = 2,
    parameter int FSUB_LAT = 2,
    parameter int FMUL_LAT = 0,
    parameter int FDIV_LAT = 10,
    parameter int FCVT_LAT = 1
) (
    input  logic [6:0]       funct7,
    output logic [LAT_W-1:0] lat
);

    // The issue counter is only LAT_W bits wide, so larger latencies cannot be sequenced.
    if (FADD_LAT > 15 || FSUB_LAT > 15 || FMUL_LAT > 15 || FDIV_LAT > 15 || FCVT_LAT > 15)
    begin : g_lat_check
        $error("fpu_lat_lut: every latency parameter must fit in 4 bits");
    end

    always_comb begin
        lat = '0;
        case (funct7)
            F7_FADD:     lat = LAT_W'(FADD_LAT);
            F7_FSUB:     lat = LAT_W'(FSUB_LAT);
            F7_FMUL:     lat = LAT_W'(FMUL_LAT);
            F7_FDIV:     lat = LAT_W'(FDIV_LAT);
            F7_FCVT_S_W: lat = LAT_W'(FCVT_LAT);
            default:     lat = '0;
        endcase
    end

endmodule

// File: rtl/fpu_issue.sv
// Single-op-in-flight issue stage: holds FPU inputs for the op's latency, captures the result
// and hands it to writeback with valid/ready.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int FADD_LAT = 2,
    parameter int FSUB_LAT = 2,
    parameter int FMUL_LAT = 0,
    parameter int FDIV_LAT = 10,
    parameter int FCVT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [DATA_W-1:0] in_x1,
    input  logic [DATA_W-1:0] in_x2,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic [2:0]        fpu_funct3,
    output logic [6:0]        fpu_funct7,
    output logic [DATA_W-1:0] fpu_x1,
    output logic [DATA_W-1:0] fpu_x2,
    input  logic [DATA_W-1:0] fpu_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              busy
);

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat;

    fpu_lat_lut #(
        .FADD_LAT(FADD_LAT),
        .FSUB_LAT(FSUB_LAT),
        .FMUL_LAT(FMUL_LAT),
        .FDIV_LAT(FDIV_LAT),
        .FCVT_LAT(FCVT_LAT)
    ) u_lat_lut (
        .funct7(in_funct7),
        .lat   (lat)
    );

    // in_ready/busy/out_valid are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            fpu_funct3 <= '0;
            fpu_funct7 <= '0;
            fpu_x1     <= '0;
            fpu_x2     <= '0;
            out_data   <= '0;
            out_rd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        fpu_funct3 <= in_funct3;
                        fpu_funct7 <= in_funct7;
                        fpu_x1     <= in_x1;
                        fpu_x2     <= in_x2;
                        out_rd     <= in_rd;
                        cnt        <= lat;
                        state      <= BUSY;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        out_data  <= fpu_y;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // A flush alongside out_ready still discards the result.
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue: a tiny table-driven FPU stand-in plus hand-computed timings.
module tb_fpu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_x1;
    logic [31:0] in_x2;
    logic [4:0]  in_rd;
    logic        flush;
    logic [2:0]  fpu_funct3;
    logic [6:0]  fpu_funct7;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic [31:0] fpu_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_issue dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_rd     (in_rd),
        .flush     (flush),
        .fpu_funct3(fpu_funct3),
        .fpu_funct7(fpu_funct7),
        .fpu_x1    (fpu_x1),
        .fpu_x2    (fpu_x2),
        .fpu_y     (fpu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Results for the handful of operand pairs used below; anything else yields a marker.
    always_comb begin
        fpu_y = 32'hDEAD_BEEF;
        case (fpu_funct7)
            7'h00: if (fpu_x1 == 32'h3F80_0000 && fpu_x2 == 32'h4000_0000) fpu_y = 32'h4040_0000;
            7'h04: if (fpu_x1 == 32'h4080_0000 && fpu_x2 == 32'h3F80_0000) fpu_y = 32'h4040_0000;
            7'h08: if (fpu_x1 == 32'h3FC0_0000 && fpu_x2 == 32'h4000_0000) fpu_y = 32'h4040_0000;
            7'h0C: if (fpu_x1 == 32'h40C0_0000 && fpu_x2 == 32'h4000_0000) fpu_y = 32'h4040_0000;
            7'h50: if (fpu_funct3 == 3'd2) fpu_y = (fpu_x1 == fpu_x2) ? 32'd1 : 32'd0;
            7'h68: if (fpu_x1 == 32'd3) fpu_y = 32'h4040_0000;
            default: fpu_y = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle; on return we are 1ns into cycle T+1.
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_funct7 = f7;
        in_funct3 = f3;
        in_x1     = a;
        in_x2     = b;
        in_rd     = rd;
        step();
        in_valid  = 1'b0;
        in_x1     = 32'h0;
        in_x2     = 32'h0;
    endtask

    // Counts cycles after the accept edge until out_valid, bounded; expects T+2+lat.
    task automatic wait_done(input string tag, input int lat);
        int n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 2 + lat);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          seen;
        rst = 1'b1; in_valid = 1'b0; in_funct3 = '0; in_funct7 = '0;
        in_x1 = '0; in_x2 = '0; in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fpu_x1", fpu_x1, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);

        // fadd 1.0 + 2.0
        issue(7'h00, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        chk("fadd_busy", {31'd0, busy}, 32'd1);
        chk("fadd_fpu_x1", fpu_x1, 32'h3F80_0000);
        wait_done("fadd", 2);
        chk("fadd_data", out_data, 32'h4040_0000);
        chk("fadd_rd", {27'd0, out_rd}, 32'd5);
        release_result();

        // feq 1.0 == 1.0
        issue(7'h50, 3'd2, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        wait_done("feq", 0);
        chk("feq_data", out_data, 32'd1);
        release_result();

        // fdiv 6.0 / 2.0 with backpressure afterwards
        issue(7'h0C, 3'd0, 32'h40C0_0000, 32'h4000_0000, 5'd17);
        seen = 0;
        for (int i = 1; i < 12; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || fpu_x1 !== 32'h40C0_0000) seen++;
            step();
        end
        chk("fdiv_hold_violations", seen, 0);
        chk("fdiv_out_valid_T12", {31'd0, out_valid}, 32'd1);
        chk("fdiv_busy_T12", {31'd0, busy}, 32'd1);
        chk("fdiv_data", out_data, 32'h4040_0000);
        in_valid = 1'b1; in_funct7 = 7'h00; in_x1 = 32'h1234_5678; in_rd = 5'd3;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || out_data !== 32'h4040_0000 || out_rd !== 5'd17
                || in_ready !== 1'b0) seen++;
        end
        chk("backpressure_violations", seen, 0);
        in_valid = 1'b0;
        release_result();

        // fsub, fmul, fcvt, and an unlisted funct7 (fsgnj -> latency 0)
        issue(7'h04, 3'd0, 32'h4080_0000, 32'h3F80_0000, 5'd1);
        wait_done("fsub", 2);
        chk("fsub_data", out_data, 32'h4040_0000);
        release_result();
        issue(7'h08, 3'd0, 32'h3FC0_0000, 32'h4000_0000, 5'd2);
        wait_done("fmul", 0);
        chk("fmul_data", out_data, 32'h4040_0000);
        release_result();
        issue(7'h68, 3'd0, 32'd3, 32'd0, 5'd4);
        wait_done("fcvt", 1);
        chk("fcvt_data", out_data, 32'h4040_0000);
        release_result();
        issue(7'h10, 3'd0, 32'h1, 32'h2, 5'd6);
        wait_done("fsgnj", 0);
        chk("fsgnj_data", out_data, 32'hDEAD_BEEF);
        release_result();

        // flush at T+5 of an fdiv
        issue(7'h0C, 3'd0, 32'h40C0_0000, 32'h4000_0000, 5'd8);
        step(); step(); step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid !== 1'b0) seen++;
            step();
        end
        chk("flush_no_out_valid", seen, 0);
        issue(7'h08, 3'd0, 32'h3FC0_0000, 32'h4000_0000, 5'd12);
        wait_done("fmul_after_flush", 0);
        chk("fmul_after_flush_data", out_data, 32'h4040_0000);
        chk("fmul_after_flush_rd", {27'd0, out_rd}, 32'd12);

        // flush together with out_ready in DONE drops the result
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_done_in_ready", {31'd0, in_ready}, 32'd1);

        // flush in IDLE suppresses an op offered the same cycle
        in_valid = 1'b1; in_funct7 = 7'h0C; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

        // rst during BUSY, then rst with flush
        for (int k = 0; k < 2; k++) begin
            issue(7'h0C, 3'd0, 32'h40C0_0000, 32'h4000_0000, 5'd21);
            step(); step();
            rst = 1'b1; flush = (k == 1);
            step();
            rst = 1'b0; flush = 1'b0;
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_fpu_x1", fpu_x1, 32'd0);
            chk("midrst_fpu_funct7", {25'd0, fpu_funct7}, 32'd0);
            chk("midrst_out_data", out_data, 32'd0);
            chk("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
